// File: rtl/accum_64.sv
// accum_64: 64-bit group accumulator fed by the upstream 64-bit adder stage.
// Operand words arrive on a valid/ready handshake and are summed (carry-in 0)
// into a 64-bit register. A word tagged with in_last closes the group. The
// total, a sticky carry-out flag and a saturating word count are then held
// on the output handshake until downstream accepts them.
//
// Build option: define ACC_SATURATE_EN to clamp the accumulator at all-ones
// once any add in the group carries out of bit 63. Without it the
// accumulator wraps modulo 2^64, and out_c_out records that a wrap occurred.
module accum_64 #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  input  logic             in_last,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_sum,
  output logic             out_c_out,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [63:0]      acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [64:0]      sum_s;
  logic [63:0]      acc_next_s;
  logic             in_fire_s;
  logic             out_fire_s;

  // Increment that sticks at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  // A clear in ACCUM drops in_ready, so a word offered alongside it is held back.
  assign in_ready   = (state_q == ST_ACCUM) && !clear;
  assign out_valid  = (state_q == ST_HOLD);
  assign in_fire_s  = in_valid && in_ready;
  assign out_fire_s = out_valid && out_ready;

  // The result ports show the live accumulation state in both states.
  assign out_sum    = acc_q;
  assign out_c_out  = carry_q;
  assign out_count  = count_q;

  // 65-bit add; bit 64 is the carry out of bit 63.
  assign sum_s = {1'b0, acc_q} + {1'b0, in_data};

  // Accumulator value after accepting the current word.
  always_comb begin
    acc_next_s = sum_s[63:0];
`ifdef ACC_SATURATE_EN
    // Once the group has carried, the total stays clamped at all-ones.
    if (sum_s[64] || carry_q) begin
      acc_next_s = 64'hFFFF_FFFF_FFFF_FFFF;
    end else begin
      acc_next_s = sum_s[63:0];
    end
`endif
  end

  // Next-state logic for the ACCUM/HOLD sequencer and the accumulation registers.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    count_d = count_q;
    case (state_q)
      ST_ACCUM: begin
        if (clear) begin
          acc_d   = 64'h0;
          carry_d = 1'b0;
          count_d = '0;
          state_d = ST_ACCUM;
        end else if (in_fire_s) begin
          acc_d   = acc_next_s;
          carry_d = carry_q | sum_s[64];
          count_d = sat_inc(count_q);
          if (in_last) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_HOLD: begin
        // clear is ignored here so a finished result is never dropped.
        if (out_fire_s) begin
          acc_d   = 64'h0;
          carry_d = 1'b0;
          count_d = '0;
          state_d = ST_ACCUM;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        acc_d   = 64'h0;
        carry_d = 1'b0;
        count_d = '0;
        state_d = ST_ACCUM;
      end
    endcase
  end

  // State and accumulation registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      acc_q   <= 64'h0;
      carry_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_accum_64.sv
// Testbench for accum_64: directed steps plus random groups, checked against
// a wide-integer model of the running group total.
module tb_accum_64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = 64'h0;
  logic        in_last = 1'b0;
  logic        clear = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_c_out;
  logic [63:0] out_sum;
  logic [7:0]  out_count;

  logic        b_in_ready, b_out_valid, b_out_c_out;
  logic [63:0] b_out_sum;
  logic [1:0]  b_out_count;

  int n_cmp = 0;
  int n_fail = 0;

  // Model: exact (unwrapped) sum of the group's words and the number of words.
  logic [127:0] m_total = 128'h0;
  int           m_n = 0;

  always #5 clk = ~clk;

  accum_64 #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_c_out(out_c_out), .out_count(out_count)
  );

  accum_64 #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_last(in_last), .clear(clear),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_sum(b_out_sum),
    .out_c_out(b_out_c_out), .out_count(b_out_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_sum();
`ifdef ACC_SATURATE_EN
    if (|m_total[127:64]) return 64'hFFFF_FFFF_FFFF_FFFF;
`endif
    return m_total[63:0];
  endfunction

  function automatic logic exp_carry();
    return |m_total[127:64];
  endfunction

  function automatic logic [63:0] exp_cnt(input int maxv);
    return 64'((m_n > maxv) ? maxv : m_n);
  endfunction

  task automatic model_zero();
    m_total = 128'h0;
    m_n = 0;
  endtask

  task automatic check_result(input string tag);
    chk({tag, ".valid"}, {63'h0, out_valid}, 64'h1);
    chk({tag, ".sum"},   out_sum, exp_sum());
    chk({tag, ".c"},     {63'h0, out_c_out}, {63'h0, exp_carry()});
    chk({tag, ".count"}, {56'h0, out_count}, exp_cnt(255));
    chk({tag, ".ready"}, {63'h0, in_ready}, 64'h0);
  endtask

  task automatic check_accum(input string tag);
    chk({tag, ".valid"}, {63'h0, out_valid}, 64'h0);
    chk({tag, ".ready"}, {63'h0, in_ready}, 64'h1);
    chk({tag, ".sum"},   out_sum, exp_sum());
    chk({tag, ".c"},     {63'h0, out_c_out}, {63'h0, exp_carry()});
    chk({tag, ".count"}, {56'h0, out_count}, exp_cnt(255));
  endtask

  task automatic send(input logic [63:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    clear    = 1'b0;
    #1;
    chk("send.ready", {63'h0, in_ready}, 64'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    m_total  = m_total + {64'h0, d};
    m_n++;
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    model_zero();
    check_accum(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(posedge clk); #1;
    model_zero();
    check_accum(tag);
    rst = 1'b0;
  endtask

  initial begin
    logic [63:0] d;
    int len;

    // Reset state
    do_reset("reset");

    // 5, 7, 9 (last) -> 21, count 3
    send(64'd5, 1'b0);
    send(64'd7, 1'b0);
    send(64'd9, 1'b1);
    check_result("g579");
    chk("g579.sum_const", out_sum, 64'd21);

    // Back-pressure: result stays stable for 4 cycles
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_result("hold_stable");
    end
    take("after_take");

    // Carry out of bit 63
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send(64'd2, 1'b1);
    check_result("carry");
`ifdef ACC_SATURATE_EN
    chk("carry.sum_const", out_sum, 64'hFFFF_FFFF_FFFF_FFFF);
`else
    chk("carry.sum_const", out_sum, 64'd1);
`endif
    take("carry_take");

    // clear beats a same-cycle word
    send(64'd10, 1'b0);
    in_valid = 1'b1;
    in_data  = 64'd3;
    clear    = 1'b1;
    #1;
    chk("clear.ready", {63'h0, in_ready}, 64'h0);
    @(posedge clk); #1;
    clear = 1'b0;
    model_zero();
    chk("clear.sum", out_sum, 64'h0);
    chk("clear.count", {56'h0, out_count}, 64'h0);
    send(64'd3, 1'b1);
    check_result("after_clear");
    chk("after_clear.count_const", {56'h0, out_count}, 64'd1);

    // clear and a new word in HOLD are both ignored
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 64'd99;
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    check_result("hold_clear");
    take("hold_clear_take");

    // Single zero word: sum 0, count 1
    send(64'h0, 1'b1);
    check_result("zero_word");
    take("zero_take");

    // Random groups with idle gaps and random back-pressure
    for (int g = 0; g < 10; g++) begin
      len = $urandom_range(1, 8);
      for (int w = 0; w < len; w++) begin
        if ($urandom_range(0, 2) == 0) d = 64'($urandom_range(0, 1000));
        else d = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
          check_accum("rand_idle");
        end
        send(d, w == len - 1);
      end
      check_result("rand_group");
      for (int k = $urandom_range(0, 3); k > 0; k--) begin
        @(posedge clk); #1;
        check_result("rand_hold");
      end
      take("rand_take");
    end

    // Count saturates at 255 for CNT_W=8
    for (int w = 0; w < 300; w++) send(64'($urandom_range(0, 15)), w == 299);
    check_result("cnt_sat8");
    take("cnt_sat8_take");

    // Reset in mid-group
    send(64'd77, 1'b0);
    do_reset("reset_mid");

    // CNT_W=2 instance: five ones -> count 3, sum 5
    for (int w = 0; w < 5; w++) send(64'd1, w == 4);
    check_result("five_ones");
    chk("w2.valid", {63'h0, b_out_valid}, 64'h1);
    chk("w2.count", {62'h0, b_out_count}, exp_cnt(3));
    chk("w2.count_const", {62'h0, b_out_count}, 64'd3);
    chk("w2.sum", b_out_sum, 64'd5);
    chk("w2.ready", {63'h0, b_in_ready}, 64'h0);

    // Reset while in HOLD
    do_reset("reset_hold");
    chk("w2r.valid", {63'h0, b_out_valid}, 64'h0);
    chk("w2r.sum", b_out_sum, 64'h0);
    chk("w2r.c", {63'h0, b_out_c_out}, 64'h0);
    chk("w2r.count", {62'h0, b_out_count}, 64'h0);
    chk("w2r.ready", {63'h0, b_in_ready}, 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/accum_64.md
# accum_64

Sequential 64-bit accumulator that sits directly downstream of the 64-bit adder stage and consumes its sum/carry result. Operand words arrive over a valid/ready handshake and are summed into a 64-bit register (carry-in fixed at 0). A group ends on a `last`-tagged word, and the group total is presented on a second valid/ready handshake. The block adds a group count and a sticky carry flag.

## Interface
- `CNT_W`, default 8: width of the operand counter; counter saturates at 2^CNT_W-1.
- `clk` in 1: single clock; everything is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operand word valid.
- `in_ready` out 1: block can accept an operand.
- `in_data` in 64: operand, unsigned.
- `in_last` in 1: qualifies `in_data` as the final word of the group.
- `clear` in 1: abort the current group and zero the accumulation.
- `out_valid` out 1: group result valid.
- `out_ready` in 1: downstream accepts the result.
- `out_sum` out 64: group total.
- `out_c_out` out 1: sticky carry; set if any add in the group produced carry-out of bit 63.
- `out_count` out CNT_W: number of words accepted in the group.

## Operation
- States:
  - ACCUM: accepting operands.
  - HOLD: result presented.
- Transfer definitions:
  - Input transfer: `in_valid && in_ready`.
  - Output transfer: `out_valid && out_ready`.
- `in_ready` = (state == ACCUM) && !`clear`. It is combinational and does not depend on `in_valid`.
- `out_valid` = (state == HOLD).
- On an input transfer in ACCUM:
  - acc <= acc + `in_data`, computed as a 65-bit add. Bit 64 is the carry.
  - carry_flag <= carry_flag | carry.
  - count <= count + 1, saturating at all-ones.
  - If `in_last`, go to HOLD.
- In HOLD:
  - acc, count and carry_flag are frozen.
  - `out_sum`, `out_c_out` and `out_count` are stable and do not change while `out_valid` is high and `out_ready` is low.
- On an output transfer: acc, count and carry_flag are zeroed, and the state returns to ACCUM.
- `clear` in ACCUM:
  - acc, count and carry_flag are zeroed.
  - `in_ready` is low that cycle, so no word is accepted.
- `clear` in HOLD is ignored. A result is never dropped.
- Empty group: a word with `in_last` is always counted. A group therefore has count ≥ 1, and a group consisting of a single `in_data`=0 gives sum 0, count 1.
- Wrap-around without saturation: acc wraps modulo 2^64 and `out_c_out` records that a wrap occurred.
- `out_sum`, `out_c_out` and `out_count` show the live acc, carry_flag and count in both states. They are qualified only by `out_valid`.

## Timing
- Reset: state=ACCUM, acc=0, count=0, carry_flag=0.
  - Outputs after reset: `out_valid`=0, `out_sum`=0, `out_c_out`=0, `out_count`=0, `in_ready`=1 (when `clear`=0).
- Reset mid-group or mid-HOLD discards everything with no output transfer.
- Latency: when the last word is accepted at edge N, `out_valid`=1 in the cycle after edge N, carrying the total including that word.
- Throughput:
  - One word per cycle in ACCUM.
  - HOLD lasts at least one cycle, so a group of k words occupies at least k+1 cycles.
  - `in_ready` is 0 throughout HOLD. No overlap between groups.
- When the output transfer occurs at edge M, `in_ready` returns to 1 in the cycle after edge M.
- Same-cycle `in_valid` and `clear` in ACCUM: `clear` wins and the word is not consumed. The source holds it under handshake rules.

## Configuration
- `ACC_SATURATE_EN` defined (saturating mode):
  - If an add in the group produces a carry, acc is set to 64'hFFFF_FFFF_FFFF_FFFF.
  - acc stays at all-ones for the rest of the group.
  - `out_c_out` is still set.
- `ACC_SATURATE_EN` undefined: modulo-2^64 wrap, as described in Operation.
- Reset, `clear` and the output transfer zero acc in both modes.

## Test plan
- Reset, then words 5, 7, 9 on consecutive cycles with `in_last` on the 9 -> one cycle later `out_valid`=1, `out_sum`=21, `out_count`=3, `out_c_out`=0, `in_ready`=0.
- Hold `out_ready`=0 for 4 cycles, then raise it -> outputs are stable throughout. The cycle after the transfer, `out_valid`=0, `in_ready`=1 and `out_sum`=0.
- Words 64'hFFFF_FFFF_FFFF_FFFF and 2 (last):
  - Without the macro -> `out_sum`=1, `out_c_out`=1, `out_count`=2.
  - With `ACC_SATURATE_EN` -> `out_sum`=all-ones, `out_c_out`=1.
- Word 10, then `clear` asserted together with `in_valid` on word 3, then 3 (last) on the next cycle -> `in_ready`=0 during the `clear` cycle. Result: `out_sum`=3, `out_count`=1.
- `CNT_W`=2 with 5 words of value 1 -> `out_count`=3 (saturated) and `out_sum`=5. Then assert `rst` in HOLD -> the next cycle shows all outputs at reset values.
